// File: rtl/fixfloat_pkg.sv
// Shared float32 / fixed-point definitions: field layout, IEEE constants, input classification.
package fixfloat_pkg;
  localparam int FP32_EXP_BIAS = 127;
  localparam int FP32_MANT_W   = 23;
  localparam int FP32_EXP_MAX  = 255;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float32_t;

  typedef enum logic [1:0] {
    FPC_ZERO,
    FPC_NORM,
    FPC_INF,
    FPC_NAN
  } fp_class_t;
endpackage

// File: rtl/fp_mag_shifter.sv
// Combinational signed-amount shift of a 24-bit significand into a W+1 bit magnitude.
// Left-shift overflow is judged from the shift amount itself and from bits lost off the top.
module fp_mag_shifter #(
  parameter int W = 20
) (
  input  logic              [23:0] m_i,
  input  logic signed       [9:0]  sh_i,
  output logic              [W:0]  mag_o,
  output logic                     ovf_shift_o
);
  localparam int XW = W + 25;
  localparam logic signed [9:0] W_S = 10'(W);

  logic [XW-1:0] ext;
  logic [XW-1:0] shifted;
  logic [9:0]    neg;

  assign ext = XW'(m_i);

  always_comb begin
    mag_o       = '0;
    ovf_shift_o = 1'b0;
    shifted     = '0;
    neg         = -sh_i;
    if (!sh_i[9]) begin
      if (sh_i >= W_S) begin
        ovf_shift_o = |m_i;
      end else begin
        shifted     = ext << sh_i[6:0];
        mag_o       = shifted[W:0];
        ovf_shift_o = |shifted[XW-1:W+1];
      end
    end else if (neg <= 10'd24) begin
      // Right shifts of 25 or more leave nothing of the significand.
      shifted     = ext >> neg[4:0];
      mag_o       = shifted[W:0];
      ovf_shift_o = |shifted[XW-1:W+1];
    end
  end
endmodule

// File: rtl/pipe_float32_to_fixed.sv
// Float32 to signed fixed (WOI.WOF) converter: classify, shift, saturate/negate; 3 register stages.
// Truncates toward zero, saturates with out_ovf; accepts one input per clock, no backpressure.
module pipe_float32_to_fixed
  import fixfloat_pkg::*;
#(
  parameter int WOI = 10,
  parameter int WOF = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [31:0]          in,
  output logic                 out_valid,
  output logic [WOI+WOF-1:0]   out,
  output logic                 out_ovf
);
  localparam int W = WOI + WOF;
  localparam logic signed [9:0] SH_OFS = 10'(WOF - FP32_EXP_BIAS - FP32_MANT_W);
  localparam logic [W:0]   MAG_ONE = (W+1)'(1);
  localparam logic [W:0]   MAG_NEG = MAG_ONE << (W-1);
  localparam logic [W:0]   MAG_POS = MAG_NEG - MAG_ONE;
  localparam logic [W-1:0] SAT_NEG = MAG_NEG[W-1:0];
  localparam logic [W-1:0] SAT_POS = ~SAT_NEG;

  float32_t f;
  assign f = float32_t'(in);

  fp_class_t          s1_cls_d, s1_cls_q;
  logic signed [9:0]  s1_sh_d, s1_sh_q;
  logic [23:0]        s1_mant_q;
  logic               s1_sign_q, s1_vld_q;

  always_comb begin
    s1_cls_d = FPC_NORM;
    if (f.exp == '0) begin
      s1_cls_d = FPC_ZERO;
    end else if (f.exp == 8'(FP32_EXP_MAX)) begin
      s1_cls_d = (f.mant == '0) ? FPC_INF : FPC_NAN;
    end
  end

  assign s1_sh_d = $signed({2'b00, f.exp}) + SH_OFS;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q  <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_cls_q  <= FPC_ZERO;
      s1_mant_q <= '0;
      s1_sh_q   <= '0;
    end else begin
      s1_vld_q  <= in_valid;
      s1_sign_q <= f.sign;
      s1_cls_q  <= s1_cls_d;
      s1_mant_q <= {1'b1, f.mant};
      s1_sh_q   <= s1_sh_d;
    end
  end

  logic [W:0] shf_mag;
  logic       shf_ovf;

  fp_mag_shifter #(.W(W)) u_shift (
    .m_i         (s1_mant_q),
    .sh_i        (s1_sh_q),
    .mag_o       (shf_mag),
    .ovf_shift_o (shf_ovf)
  );

  fp_class_t  s2_cls_q;
  logic [W:0] s2_mag_q;
  logic       s2_ovf_q, s2_sign_q, s2_vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld_q  <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_cls_q  <= FPC_ZERO;
      s2_mag_q  <= '0;
      s2_ovf_q  <= 1'b0;
    end else begin
      s2_vld_q  <= s1_vld_q;
      s2_sign_q <= s1_sign_q;
      s2_cls_q  <= s1_cls_q;
      s2_mag_q  <= shf_mag;
      s2_ovf_q  <= shf_ovf;
    end
  end

  logic [W-1:0] out_d, out_q;
  logic         ovf_d, ovf_q, vld_q;

  // Limits are checked on the unsigned magnitude so the negative range keeps its extra LSB.
  always_comb begin
    out_d = '0;
    ovf_d = 1'b0;
    case (s2_cls_q)
      FPC_ZERO: ;
      FPC_NAN:  ovf_d = 1'b1;
      FPC_INF: begin
        ovf_d = 1'b1;
        out_d = s2_sign_q ? SAT_NEG : SAT_POS;
      end
      default: begin
        if (s2_ovf_q || (!s2_sign_q && s2_mag_q > MAG_POS) ||
            (s2_sign_q && s2_mag_q > MAG_NEG)) begin
          ovf_d = 1'b1;
          out_d = s2_sign_q ? SAT_NEG : SAT_POS;
        end else if (s2_sign_q) begin
          out_d = -s2_mag_q[W-1:0];
        end else begin
          out_d = s2_mag_q[W-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      vld_q <= s2_vld_q;
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = vld_q;
  assign out       = out_q;
  assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_pipe_float32_to_fixed.sv
// Bench for pipe_float32_to_fixed (WOI=10, WOF=10): directed literals, random stream, mid-stream reset.
module tb_pipe_float32_to_fixed;
  localparam int WOI = 10;
  localparam int WOF = 10;
  localparam int W   = WOI + WOF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_d = '0;
  logic          out_valid;
  logic [W-1:0]  out_d;
  logic          out_ovf;

  int checks = 0;
  int failures = 0;

  pipe_float32_to_fixed #(.WOI(WOI), .WOF(WOF)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in_d),
    .out_valid (out_valid),
    .out       (out_d),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: real-valued v*2^WOF, truncated toward zero, clamped to the W-bit range. Returns {ovf, out}.
  function automatic logic [W:0] model(input logic [31:0] x);
    logic [W-1:0] maxp, minn;
    logic [63:0]  t;
    int           e;
    real          mag, lim;
    maxp = '1;
    maxp[W-1] = 1'b0;
    minn = '0;
    minn[W-1] = 1'b1;
    e = int'(x[30:23]);
    if (e == 0) return '0;
    if (e == 255) begin
      if (x[22:0] == 23'd0) return {1'b1, x[31] ? minn : maxp};
      return {1'b1, {W{1'b0}}};
    end
    mag = $floor(real'(int'({1'b1, x[22:0]})) * (2.0 ** real'(e - 150 + WOF)));
    lim = 2.0 ** real'(W - 1);
    if (!x[31]) begin
      if (mag > lim - 1.0) return {1'b1, maxp};
      t = 64'(longint'(mag));
    end else begin
      if (mag > lim) return {1'b1, minn};
      t = -64'(longint'(mag));
    end
    return {1'b0, t[W-1:0]};
  endfunction

  typedef struct packed {
    logic       v;
    logic [W:0] r;
  } ent_t;
  ent_t hist[$];

  // Each sampled input is expected on the outputs right after the third edge from its sampling edge inclusive.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      hist.push_back({in_valid, model(in_d)});
      if (hist.size() > 3) void'(hist.pop_front());
    end
  end

  always @(negedge rst) hist.delete();

  initial forever begin
    ent_t e;
    @(posedge clk);
    #1;
    if (rst) begin
      if (hist.size() == 3) begin
        e = hist[0];
        chk("stream_valid", 64'(out_valid), 64'(e.v));
        if (e.v) chk("stream_data", 64'({out_ovf, out_d}), 64'(e.r));
      end else begin
        chk("fill_valid", 64'(out_valid), 64'd0);
      end
    end
  end

  function automatic logic [31:0] rnd_float();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return {1'($urandom), 8'($urandom_range(110, 150)), 23'($urandom)};
  endfunction

  logic [31:0]  dv[13]   = '{32'h3F800000, 32'hBFC00000, 32'h447A0000, 32'hC4000000,
                             32'hC4001000, 32'h3A000000, 32'hBA800000, 32'hBA000000,
                             32'h00000001, 32'h80000000, 32'h7FC00000, 32'hFF800000,
                             32'h7F800000};
  logic [W-1:0] dexp[13] = '{20'h00400, 20'hFFA00, 20'h7FFFF, 20'h80000,
                             20'h80000, 20'h00000, 20'hFFFFF, 20'h00000,
                             20'h00000, 20'h00000, 20'h00000, 20'h80000,
                             20'h7FFFF};
  logic         dovf[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int  n;
    bit  done;

    #2;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_out", 64'(out_d), 64'd0);
    chk("reset_ovf", 64'(out_ovf), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      in_d = dv[i];
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_d = '0;
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("dir_valid[%0d]", i), 64'(out_valid), 64'd1);
      chk($sformatf("dir_out[%0d]", i), 64'(out_d), 64'(dexp[i]));
      chk($sformatf("dir_ovf[%0d]", i), 64'(out_ovf), 64'(dovf[i]));
    end

    for (int i = 0; i < 43; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_d = rnd_float();
    end
    @(negedge clk); in_valid = 1'b1; in_d = rnd_float();
    @(negedge clk); in_valid = 1'b0; in_d = rnd_float();
    @(negedge clk); in_valid = 1'b1; in_d = rnd_float();
    @(negedge clk); in_valid = 1'b0; in_d = '0;
    repeat (5) @(negedge clk);

    // Three valid results in flight, the first already on the outputs, when reset hits mid-cycle.
    @(negedge clk); in_valid = 1'b1; in_d = 32'h3F800000;
    @(negedge clk); in_d = 32'hBFC00000;
    @(negedge clk); in_d = 32'h40000000;
    @(negedge clk); in_valid = 1'b0; in_d = '0;
    #2;
    chk("pre_reset_out", 64'({out_valid, out_d}), 64'({1'b1, 20'h00400}));
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_out", 64'(out_d), 64'd0);
    chk("async_rst_ovf", 64'(out_ovf), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    in_d = 32'hC0400000;
    in_valid = 1'b1;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) done = 1'b1;
      else if (i == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_d = '0;
      end
    end
    in_valid = 1'b0;
    chk("rst_recover_latency", 64'(n), 64'd3);
    chk("rst_recover_out", 64'({out_ovf, out_d}), 64'({1'b0, 20'hFF400}));
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
